bw_hpt_walker: RTL and testbench
================================

// Module: bw_hpt_walker
// PURPOSE
//  Hashed-page-table walker between the TLB and the memory bus. On a TLB miss,
//  it hashes {ASID,VPN}, reads the primary page-table group (PTG) one HPTE per
//  bus beat, then the secondary group, and returns the matching HPTE and its
//  address for the TLB refill. If neither group holds a match it reports a
//  page fault.
// PARAMETERS
//  HASH_BITS   10   log2 of PTG count in the table; group index width
//  PAGE_SHIFT  14   log2 page size; VPN = vadr_i >> PAGE_SHIFT
//  BEATS       8    HPTEs per PTG (= `PtePerPtg); one 128-bit beat each
// PORTS
//  clk_i       in   1    clock
//  rst_ni      in   1    asynchronous active-low reset
//  flush_i     in   1    abort walk, return to IDLE, no done_o
//  miss_v_i    in   1    TLB miss request; accepted only when !busy_o
//  miss_asid_i in   10   ASID of missing access
//  miss_vadr_i in   32   virtual address (Address) of missing access
//  ptbr_i      in   32   hash table base; 128-byte aligned
//  busy_o      out  1    walk in progress
//  req_o       out  1    bus read request; held until ack_i or err_i
//  adr_o       out  32   beat address
//  ack_i       in   1    beat data valid on dat_i
//  err_i       in   1    bus error terminating beat
//  dat_i       in   128  one HPTE (rfBlackWidowMmuPkg::HPTE)
//  done_o      out  1    one-cycle completion pulse
//  hit_o       out  1    with done_o: a matching HPTE was found
//  fault_o     out  1    with done_o: no match in either group (page fault)
//  berr_o      out  1    with done_o: walk ended by bus error
//  hpte_o      out  128  matched HPTE; valid while done_o & hit_o
//  hpte_adr_o  out  32   byte address of the matched HPTE (for A/M updates)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; captured ASID, VPN and hash registers 0.
//  vpn     = miss_vadr_i >> PAGE_SHIFT, zero-extended to 48 bits.
//  hash    = (vpn[HASH_BITS-1:0] ^ asid) mod 2^HASH_BITS.
//  ptg_adr = ptbr_i + {hash,7'b0}. Secondary group uses ~hash.
//  Beat i address = ptg_adr + {i,4'b0}. All arithmetic is 32-bit and wraps.
//  Match: hpte.v & {vpnhi,vpn}==vpn & (hpte.g | hpte.asid==asid).
//  FSM:
//   IDLE  : if miss_v_i, capture asid, vpn and hash; sec<=0; ->HASH.
//   HASH  : form ptg_adr; beat<=0; ->REQ.
//   REQ   : req_o=1, adr_o=beat addr. Wait here until ack_i or err_i.
//           err_i -> DONE with berr_o.
//           ack_i & match -> latch dat_i and adr_o; ->DONE with hit_o.
//           ack_i & !match & beat<BEATS-1 -> beat++; drop req_o for 1 cycle.
//           ack_i & !match & last beat & !sec -> sec<=1; ->HASH.
//           ack_i & !match & last beat & sec -> DONE with fault_o.
//   DONE  : done_o=1 plus exactly one of hit_o, fault_o or berr_o; ->IDLE.
//  Timing:
//   - First req_o rises 2 cycles after the miss is accepted.
//   - With 1-cycle ack, a slot-k primary hit gives done_o 2k+4 cycles after
//     acceptance.
//  Flags and data:
//   - Only the first matching slot is used.
//   - ack_i and err_i together: err_i wins.
//   - ack_i/err_i while req_o=0: ignored.
//   - hit_o, fault_o and berr_o are 0 whenever done_o=0.
//   - hpte_o and hpte_adr_o hold until the next hit.
//  busy_o=1 in every state except IDLE. miss_v_i while busy is ignored
//  (requester must hold it).
//  flush_i:
//   - Any state -> IDLE next cycle; req_o drops; no done_o.
//   - Beats in flight at flush: their later ack/err is ignored.
//   - flush_i wins over ack_i in the same cycle.
//  Reset mid-walk: immediate return to reset values.
// STRUCTURE
//  Shared package rfBlackWidowMmuPkg:
//   - HPTE typedef (128-bit).
//   - PTW_IDLE, PTW_HASH, PTW_REQ, PTW_DONE state encodings.
//   - `PtePerPtg constant.
//  Sub-module bw_hpte_match (combinational): HPTE, ASID, VPN -> match bit.
// TESTING
//  1 Primary hit: asid=5, vadr=0x0001_C000, ptbr=0x10000, slot 3 valid and
//    matching -> hit_o, hpte_adr_o=0x10000+{(7^5),7'b0}+0x30, 4 beats read.
//  2 Secondary hit: primary has 8 non-matching HPTEs; secondary slot 7 matches
//    -> 16 beats read; second group base uses ~hash; hit_o.
//  3 Global entry: g=1, asid field 0x3FF, request asid=2 -> hit_o. Same entry
//    with g=0 -> fault_o after 16 beats.
//  4 Bus error on beat 2 of primary group -> done_o & berr_o, no further
//    req_o. Also ack_i&err_i together -> berr_o.
//  5 flush_i during beat 5 wait -> IDLE, no done_o. A late ack_i is ignored.
//    A new miss then completes correctly.
//  6 rst_ni low mid-walk -> all outputs 0 at once. miss_v_i while busy_o ->
//    not captured.

Source files
------------

// File: rtl/rfBlackWidowMmuPkg.sv
// Shared MMU types for the BlackWidow hashed page table walker.
// HPTE layout, walker state encodings and PTG geometry.
`ifndef PtePerPtg
`define PtePerPtg 8
`endif

package rfBlackWidowMmuPkg;

  localparam int unsigned PtePerPtg = `PtePerPtg;
  localparam int unsigned AsidW = 10;
  localparam int unsigned VpnW = 48;

  typedef struct packed {
    logic        v;
    logic        g;
    logic        a;
    logic        m;
    logic [2:0]  rwx;
    logic [9:0]  asid;
    logic [15:0] vpnhi;
    logic [31:0] vpn;
    logic [31:0] ppn;
    logic [30:0] rsvd;
  } HPTE;

  typedef enum logic [1:0] {
    PTW_IDLE,
    PTW_HASH,
    PTW_REQ,
    PTW_DONE
  } ptw_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_HIT,
    RES_FAULT,
    RES_BERR
  } ptw_res_e;

endpackage

// File: rtl/bw_hpte_match.sv
// HPTE tag compare: valid, full VPN and ASID (or global) must agree.
// Purely combinational.
module bw_hpte_match
  import rfBlackWidowMmuPkg::*;
(
  input  HPTE              hpte,
  input  logic [AsidW-1:0] asid,
  input  logic [VpnW-1:0]  vpn,
  output logic             match
);

  logic vpn_eq;
  logic asid_ok;
  logic unused_ok;

  assign vpn_eq  = {hpte.vpnhi, hpte.vpn} == vpn;
  assign asid_ok = hpte.g || (hpte.asid == asid);
  assign match   = hpte.v && vpn_eq && asid_ok;

  // Permission and translation fields are for the TLB, not the tag.
  assign unused_ok = ^{hpte.a, hpte.m, hpte.rwx,
                       hpte.ppn, hpte.rsvd};

endmodule

// File: rtl/bw_hpt_walker.sv
// Hashed page table walker: primary then secondary PTG scan,
// one HPTE per bus beat, single-cycle done pulse with result.
module bw_hpt_walker
  import rfBlackWidowMmuPkg::*;
#(
  parameter int unsigned HASH_BITS  = 10,
  parameter int unsigned PAGE_SHIFT = 14,
  parameter int unsigned BEATS      = PtePerPtg
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              miss_v_i,
  input  logic [AsidW-1:0]  miss_asid_i,
  input  logic [31:0]       miss_vadr_i,
  input  logic [31:0]       ptbr_i,
  output logic              busy_o,
  output logic              req_o,
  output logic [31:0]       adr_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic [127:0]      dat_i,
  output logic              done_o,
  output logic              hit_o,
  output logic              fault_o,
  output logic              berr_o,
  output logic [127:0]      hpte_o,
  output logic [31:0]       hpte_adr_o
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  ptw_state_e           state_q, state_d;
  ptw_res_e             res_q, res_d;
  logic [AsidW-1:0]     asid_q, asid_d;
  logic [VpnW-1:0]      vpn_q, vpn_d;
  logic [HASH_BITS-1:0] hash_q, hash_d;
  logic                 sec_q, sec_d;
  logic                 chk_q, chk_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [31:0]          ptg_q, ptg_d;
  HPTE                  dat_q, dat_d;
  HPTE                  hpte_q, hpte_d;
  logic [31:0]          hadr_q, hadr_d;

  logic [VpnW-1:0]      miss_vpn;
  logic [HASH_BITS-1:0] grp;
  logic [31:0]          beat_adr;
  logic                 last_beat;
  logic                 match;

  assign miss_vpn  = VpnW'(miss_vadr_i >> PAGE_SHIFT);
  assign grp       = sec_q ? ~hash_q : hash_q;
  assign beat_adr  = ptg_q + (32'(beat_q) << 4);
  assign last_beat = beat_q == BW'(BEATS - 1);

  bw_hpte_match u_match (
    .hpte  (dat_q),
    .asid  (asid_q),
    .vpn   (vpn_q),
    .match (match)
  );

  assign busy_o     = state_q != PTW_IDLE;
  assign req_o      = (state_q == PTW_REQ) && !chk_q;
  assign adr_o      = req_o ? beat_adr : '0;
  assign done_o     = state_q == PTW_DONE;
  assign hit_o      = done_o && (res_q == RES_HIT);
  assign fault_o    = done_o && (res_q == RES_FAULT);
  assign berr_o     = done_o && (res_q == RES_BERR);
  assign hpte_o     = hpte_q;
  assign hpte_adr_o = hadr_q;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    asid_d  = asid_q;
    vpn_d   = vpn_q;
    hash_d  = hash_q;
    sec_d   = sec_q;
    chk_d   = chk_q;
    beat_d  = beat_q;
    ptg_d   = ptg_q;
    dat_d   = dat_q;
    hpte_d  = hpte_q;
    hadr_d  = hadr_q;
    unique case (state_q)
      PTW_IDLE: begin
        if (miss_v_i) begin
          asid_d  = miss_asid_i;
          vpn_d   = miss_vpn;
          hash_d  = miss_vpn[HASH_BITS-1:0]
                  ^ HASH_BITS'(miss_asid_i);
          sec_d   = 1'b0;
          state_d = PTW_HASH;
        end
      end
      PTW_HASH: begin
        ptg_d   = ptbr_i + (32'(grp) << 7);
        beat_d  = '0;
        chk_d   = 1'b0;
        state_d = PTW_REQ;
      end
      PTW_REQ: begin
        // The compare cycle doubles as the req_o gap between beats.
        if (!chk_q) begin
          if (err_i) begin
            res_d   = RES_BERR;
            state_d = PTW_DONE;
          end else if (ack_i) begin
            dat_d = dat_i;
            chk_d = 1'b1;
          end
        end else begin
          chk_d = 1'b0;
          if (match) begin
            res_d   = RES_HIT;
            hpte_d  = dat_q;
            hadr_d  = beat_adr;
            state_d = PTW_DONE;
          end else if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else if (!sec_q) begin
            sec_d   = 1'b1;
            state_d = PTW_HASH;
          end else begin
            res_d   = RES_FAULT;
            state_d = PTW_DONE;
          end
        end
      end
      PTW_DONE: state_d = PTW_IDLE;
      default:  state_d = PTW_IDLE;
    endcase
    if (flush_i) begin
      state_d = PTW_IDLE;
      chk_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PTW_IDLE;
      res_q   <= RES_NONE;
      asid_q  <= '0;
      vpn_q   <= '0;
      hash_q  <= '0;
      sec_q   <= 1'b0;
      chk_q   <= 1'b0;
      beat_q  <= '0;
      ptg_q   <= '0;
      dat_q   <= '0;
      hpte_q  <= '0;
      hadr_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      asid_q  <= asid_d;
      vpn_q   <= vpn_d;
      hash_q  <= hash_d;
      sec_q   <= sec_d;
      chk_q   <= chk_d;
      beat_q  <= beat_d;
      ptg_q   <= ptg_d;
      dat_q   <= dat_d;
      hpte_q  <= hpte_d;
      hadr_q  <= hadr_d;
    end
  end

endmodule

// File: tb/tb_bw_hpt_walker.sv
// Directed bench for bw_hpt_walker with a table-backed
// zero-wait bus responder.
module tb_bw_hpt_walker;
  import rfBlackWidowMmuPkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic         miss_v_i;
  logic [9:0]   miss_asid_i;
  logic [31:0]  miss_vadr_i;
  logic [31:0]  ptbr_i;
  logic         busy_o;
  logic         req_o;
  logic [31:0]  adr_o;
  logic         ack_i;
  logic         err_i;
  logic [127:0] dat_i;
  logic         done_o;
  logic         hit_o;
  logic         fault_o;
  logic         berr_o;
  logic [127:0] hpte_o;
  logic [31:0]  hpte_adr_o;

  logic         ack_en, err_en, stall_en, force_ack;
  logic [31:0]  err_adr, stall_adr;
  logic [31:0]  tab_adr [16];
  logic [127:0] tab_dat [16];
  int           tab_n;

  int total = 0;
  int bad = 0;
  int dc, nb, fr, n;
  logic acc;
  HPTE e1, e2, e3, e5;

  always #5 clk_i = ~clk_i;

  bw_hpt_walker dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .miss_v_i    (miss_v_i),
    .miss_asid_i (miss_asid_i),
    .miss_vadr_i (miss_vadr_i),
    .ptbr_i      (ptbr_i),
    .busy_o      (busy_o),
    .req_o       (req_o),
    .adr_o       (adr_o),
    .ack_i       (ack_i),
    .err_i       (err_i),
    .dat_i       (dat_i),
    .done_o      (done_o),
    .hit_o       (hit_o),
    .fault_o     (fault_o),
    .berr_o      (berr_o),
    .hpte_o      (hpte_o),
    .hpte_adr_o  (hpte_adr_o)
  );

  always_comb begin
    ack_i = force_ack ||
            (req_o && ack_en &&
             !(stall_en && adr_o == stall_adr));
    err_i = req_o && err_en && adr_o == err_adr;
    dat_i = '0;
    for (int i = 0; i < 16; i++)
      if (i < tab_n && tab_adr[i] == adr_o)
        dat_i = tab_dat[i];
  end

  function automatic HPTE mk(input logic v, input logic g,
                             input logic [9:0] asid,
                             input logic [15:0] vhi,
                             input logic [31:0] vpn,
                             input logic [31:0] ppn);
    HPTE h;
    h = '0;
    h.v = v; h.g = g; h.asid = asid;
    h.vpnhi = vhi; h.vpn = vpn; h.ppn = ppn;
    h.rwx = 3'b101; h.a = 1'b1;
    return h;
  endfunction

  task automatic put(input logic [31:0] a, input HPTE d);
    tab_adr[tab_n] = a;
    tab_dat[tab_n] = d;
    tab_n++;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic miss(input logic [9:0] asid,
                      input logic [31:0] vadr);
    miss_v_i    = 1'b1;
    miss_asid_i = asid;
    miss_vadr_i = vadr;
    @(negedge clk_i);
    miss_v_i = 1'b0;
  endtask

  // Cycle 0 is the cycle the miss is presented in.
  task automatic walk(input int cs, input int mx,
                      output int dcyc, output int nbt,
                      output int freq);
    int c;
    c = cs; nbt = 0; freq = -1;
    while (!done_o && c < mx) begin
      if (req_o && freq < 0) freq = c;
      if (req_o && (ack_i || err_i)) nbt++;
      @(negedge clk_i);
      c++;
    end
    dcyc = c;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; miss_v_i = 1'b0;
    miss_asid_i = '0; miss_vadr_i = '0; ptbr_i = '0;
    ack_en = 1'b1; err_en = 1'b0; stall_en = 1'b0;
    force_ack = 1'b0; err_adr = '0; stall_adr = '0;
    tab_n = 0;
    repeat (3) @(negedge clk_i);
    check("rst_flags", {busy_o, req_o, done_o,
                        hit_o, fault_o, berr_o}, 6'd0);
    check("rst_adr", adr_o, 32'd0);
    check("rst_hpte", hpte_o, 128'd0);
    check("rst_hadr", hpte_adr_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: primary hit in slot 3, slot 5 also matches
    e1 = mk(1, 0, 10'd5, 16'd0, 32'd7, 32'hABCDE);
    tab_n = 0;
    put(32'h0001_0110, mk(1, 0, 10'd6, 16'd0, 32'd7, 32'h1));
    put(32'h0001_0130, e1);
    put(32'h0001_0150, mk(1, 0, 10'd5, 16'd0, 32'd7, 32'h2));
    ptbr_i = 32'h0001_0000;
    miss(10'd5, 32'h0001_C000);
    walk(1, 100, dc, nb, fr);
    check("t1_done", done_o, 1'b1);
    check("t1_first_req", fr, 2);
    check("t1_done_cyc", dc, 10);
    check("t1_beats", nb, 4);
    check("t1_flags", {hit_o, fault_o, berr_o}, 3'b100);
    check("t1_hpte", hpte_o, e1);
    check("t1_hadr", hpte_adr_o, 32'h0001_0130);
    @(negedge clk_i);
    check("t1_after", {done_o, hit_o, busy_o, req_o}, 4'd0);

    // 2: primary misses, secondary slot 7 hits
    e2 = mk(1, 0, 10'h12, 16'd0, 32'h100, 32'h2222);
    tab_n = 0;
    put(32'h0001_8900, mk(1, 0, 10'h12, 16'd1, 32'h100, 32'h0));
    for (int i = 1; i < 8; i++)
      put(32'h0001_8900 + 32'(i * 16),
          mk(1, 0, 10'h12, 16'd0, 32'h101, 32'(i)));
    put(32'h0002_76F0, e2);
    miss(10'h12, 32'h0040_0000);
    walk(1, 100, dc, nb, fr);
    check("t2_done", done_o, 1'b1);
    check("t2_done_cyc", dc, 35);
    check("t2_beats", nb, 16);
    check("t2_flags", {hit_o, fault_o, berr_o}, 3'b100);
    check("t2_hpte", hpte_o, e2);
    check("t2_hadr", hpte_adr_o, 32'h0002_76F0);
    @(negedge clk_i);

    // 3: global entry hits; same entry non-global faults
    e3 = mk(1, 1, 10'h3FF, 16'd0, 32'd2, 32'h3333);
    tab_n = 0;
    put(32'h0002_0000, e3);
    ptbr_i = 32'h0002_0000;
    miss(10'd2, 32'h0000_8000);
    walk(1, 100, dc, nb, fr);
    check("t3g_done", done_o, 1'b1);
    check("t3g_done_cyc", dc, 4);
    check("t3g_flags", {hit_o, fault_o, berr_o}, 3'b100);
    check("t3g_hpte", hpte_o, e3);
    check("t3g_hadr", hpte_adr_o, 32'h0002_0000);
    @(negedge clk_i);
    tab_n = 0;
    put(32'h0002_0000, mk(1, 0, 10'h3FF, 16'd0, 32'd2, 32'h3333));
    miss(10'd2, 32'h0000_8000);
    walk(1, 100, dc, nb, fr);
    check("t3n_done", done_o, 1'b1);
    check("t3n_done_cyc", dc, 35);
    check("t3n_beats", nb, 16);
    check("t3n_flags", {hit_o, fault_o, berr_o}, 3'b010);
    check("t3n_hpte_hold", hpte_o, e3);
    check("t3n_hadr_hold", hpte_adr_o, 32'h0002_0000);
    @(negedge clk_i);

    // 4: bus error on beat 2, then ack and err together
    tab_n = 0;
    ptbr_i = 32'h0003_0000;
    err_en = 1'b1;
    err_adr = 32'h0003_0020;
    miss(10'd1, 32'h0000_4000);
    walk(1, 100, dc, nb, fr);
    check("t4_done", done_o, 1'b1);
    check("t4_done_cyc", dc, 7);
    check("t4_beats", nb, 3);
    check("t4_flags", {hit_o, fault_o, berr_o}, 3'b001);
    check("t4_hpte_hold", hpte_o, e3);
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      acc = acc | req_o | busy_o | done_o;
    end
    check("t4_quiet", acc, 1'b0);
    err_adr = 32'h0003_0000;
    miss(10'd1, 32'h0000_4000);
    walk(1, 100, dc, nb, fr);
    check("t4b_done_cyc", dc, 3);
    check("t4b_flags", {hit_o, fault_o, berr_o}, 3'b001);
    err_en = 1'b0;
    @(negedge clk_i);

    // 5: flush while beat 5 waits, late ack, then a clean walk
    tab_n = 0;
    ptbr_i = 32'h0004_0000;
    stall_en = 1'b1;
    stall_adr = 32'h0004_0050;
    miss(10'd3, 32'h0000_C000);
    n = 1;
    while (!(req_o && adr_o == 32'h0004_0050) && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("t5_beat5_cyc", n, 12);
    repeat (2) @(negedge clk_i);
    check("t5_req_held", {req_o, adr_o}, {1'b1, 32'h0004_0050});
    flush_i = 1'b1;
    stall_en = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("t5_flushed", {busy_o, req_o, done_o}, 3'd0);
    check("t5_adr", adr_o, 32'd0);
    force_ack = 1'b1;
    @(negedge clk_i);
    force_ack = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | busy_o | done_o | req_o;
      @(negedge clk_i);
    end
    check("t5_late_ack", acc, 1'b0);
    e5 = mk(1, 0, 10'd3, 16'd0, 32'd3, 32'h5555);
    put(32'h0004_0010, e5);
    miss(10'd3, 32'h0000_C000);
    walk(1, 100, dc, nb, fr);
    check("t5_done_cyc", dc, 6);
    check("t5_flags", {hit_o, fault_o, berr_o}, 3'b100);
    check("t5_hpte", hpte_o, e5);
    check("t5_hadr", hpte_adr_o, 32'h0004_0010);
    @(negedge clk_i);

    // 6: miss while busy is ignored; reset mid-walk
    tab_n = 0;
    put(32'h0001_0130, e1);
    ptbr_i = 32'h0001_0000;
    miss(10'd5, 32'h0001_C000);
    miss_v_i = 1'b1;
    miss_asid_i = 10'd2;
    miss_vadr_i = 32'h0000_8000;
    repeat (2) @(negedge clk_i);
    miss_v_i = 1'b0;
    walk(3, 100, dc, nb, fr);
    check("t6_done_cyc", dc, 10);
    check("t6_flags", {hit_o, fault_o, berr_o}, 3'b100);
    check("t6_hadr", hpte_adr_o, 32'h0001_0130);
    @(negedge clk_i);
    check("t6_idle", busy_o, 1'b0);
    miss(10'd5, 32'h0001_C000);
    @(negedge clk_i);
    check("t6_req_up", req_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_flags", {busy_o, req_o, done_o,
                           hit_o, fault_o, berr_o}, 6'd0);
    check("t6_rst_adr", adr_o, 32'd0);
    check("t6_rst_hpte", hpte_o, 128'd0);
    check("t6_rst_hadr", hpte_adr_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    miss(10'd5, 32'h0001_C000);
    walk(1, 100, dc, nb, fr);
    check("t6_recover_cyc", dc, 10);
    check("t6_recover_hpte", hpte_o, e1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
